// File: rtl/riscv_mem_arbiter.sv
// Shares one external memory port between instruction fetch and data access, one request in flight at a time.
// Round-robin on contention; data size codes become byte strobes and lane-aligned store data.
module riscv_mem_arbiter #(
    parameter int MP_DATA_WIDTH = 32,
    parameter int MP_ADDR_WIDTH = 32
) (
    input  logic                     iclk,
    input  logic                     irst_n,
    input  logic                     iimem_req,
    input  logic [MP_ADDR_WIDTH-1:0] iimem_addr,
    output logic [MP_DATA_WIDTH-1:0] oimem_rd_data,
    output logic                     oimem_ack,
    input  logic                     idmem_req,
    input  logic                     idmem_we,
    input  logic [MP_ADDR_WIDTH-1:0] idmem_addr,
    input  logic [MP_DATA_WIDTH-1:0] idmem_wr_data,
    input  logic [1:0]               idmem_wr_be,
    output logic [MP_DATA_WIDTH-1:0] odmem_rd_data,
    output logic                     odmem_ack,
    output logic                     odmem_err,
    output logic                     ostall,
    output logic                     omem_req,
    output logic                     omem_we,
    output logic [MP_ADDR_WIDTH-1:0] omem_addr,
    output logic [MP_DATA_WIDTH-1:0] omem_wr_data,
    output logic [3:0]               omem_wr_be,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [MP_DATA_WIDTH-1:0] imem_rd_data
);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                   state_reg;
    logic                     last_data_reg;
    logic                     win_data_reg;
    logic                     pick_data;
    logic                     dmem_bad;
    logic [3:0]               st_be;
    logic [MP_DATA_WIDTH-1:0] st_data;
    logic                     unused_addr_bits;

    // Fetch addresses are word-aligned; their low bits carry no information.
    assign unused_addr_bits = ^iimem_addr[1:0];

    assign ostall = (iimem_req & ~oimem_ack) | (idmem_req & ~odmem_ack);

    // Data wins when it is alone, or when both pend and fetch was granted last.
    assign pick_data = idmem_req & (~iimem_req | ~last_data_reg);

    assign dmem_bad = (idmem_wr_be == 2'b11)
                    | ((idmem_wr_be == SZ_HALF) & idmem_addr[0])
                    | ((idmem_wr_be == SZ_WORD) & (|idmem_addr[1:0]));

    always_comb begin
        st_be = 4'b1111;
        case (idmem_wr_be)
            SZ_BYTE: st_be = 4'b0001 << idmem_addr[1:0];
            SZ_HALF: st_be = idmem_addr[1] ? 4'b1100 : 4'b0011;
            default: st_be = 4'b1111;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_src;
            always_comb begin
                lane_src = idmem_wr_data[8*gi +: 8];
                case (idmem_wr_be)
                    SZ_BYTE: lane_src = idmem_wr_data[7:0];
                    SZ_HALF: lane_src = idmem_wr_data[8*(gi%2) +: 8];
                    default: lane_src = idmem_wr_data[8*gi +: 8];
                endcase
            end
            assign st_data[8*gi +: 8] = st_be[gi] ? lane_src : 8'd0;
        end
    endgenerate

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_reg     <= IDLE;
            last_data_reg <= 1'b1;
            win_data_reg  <= 1'b0;
            oimem_rd_data <= '0;
            oimem_ack     <= 1'b0;
            odmem_rd_data <= '0;
            odmem_ack     <= 1'b0;
            odmem_err     <= 1'b0;
            omem_req      <= 1'b0;
            omem_we       <= 1'b0;
            omem_addr     <= '0;
            omem_wr_data  <= '0;
            omem_wr_be    <= 4'b0000;
        end else begin
            oimem_ack <= 1'b0;
            odmem_ack <= 1'b0;
            odmem_err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (iimem_req | idmem_req) begin
                        last_data_reg <= pick_data;
                        win_data_reg  <= pick_data;
                        if (pick_data && dmem_bad) begin
                            odmem_ack <= 1'b1;
                            odmem_err <= 1'b1;
                            state_reg <= RESP;
                        end else begin
                            omem_req  <= 1'b1;
                            state_reg <= ISSUE;
                            if (pick_data) begin
                                omem_we      <= idmem_we;
                                omem_addr    <= {idmem_addr[MP_ADDR_WIDTH-1:2], 2'b00};
                                omem_wr_be   <= idmem_we ? st_be : 4'b0000;
                                omem_wr_data <= idmem_we ? st_data : '0;
                            end else begin
                                omem_we      <= 1'b0;
                                omem_addr    <= {iimem_addr[MP_ADDR_WIDTH-1:2], 2'b00};
                                omem_wr_be   <= 4'b0000;
                                omem_wr_data <= '0;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (imem_gnt) begin
                        omem_req  <= 1'b0;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (win_data_reg) begin
                            odmem_rd_data <= imem_rd_data;
                            odmem_ack     <= 1'b1;
                        end else begin
                            oimem_rd_data <= imem_rd_data;
                            oimem_ack     <= 1'b1;
                        end
                        state_reg <= RESP;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Randomised bench for riscv_mem_arbiter against a transaction-level timing model of the arbiter.
module tb_riscv_mem_arbiter;
    logic        iclk = 1'b0;
    logic        irst_n;
    logic        iimem_req;
    logic [31:0] iimem_addr;
    logic [31:0] oimem_rd_data;
    logic        oimem_ack;
    logic        idmem_req;
    logic        idmem_we;
    logic [31:0] idmem_addr;
    logic [31:0] idmem_wr_data;
    logic [1:0]  idmem_wr_be;
    logic [31:0] odmem_rd_data;
    logic        odmem_ack;
    logic        odmem_err;
    logic        ostall;
    logic        omem_req;
    logic        omem_we;
    logic [31:0] omem_addr;
    logic [31:0] omem_wr_data;
    logic [3:0]  omem_wr_be;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rd_data;

    riscv_mem_arbiter #(.MP_DATA_WIDTH(32), .MP_ADDR_WIDTH(32)) dut (
        .iclk(iclk), .irst_n(irst_n),
        .iimem_req(iimem_req), .iimem_addr(iimem_addr),
        .oimem_rd_data(oimem_rd_data), .oimem_ack(oimem_ack),
        .idmem_req(idmem_req), .idmem_we(idmem_we), .idmem_addr(idmem_addr),
        .idmem_wr_data(idmem_wr_data), .idmem_wr_be(idmem_wr_be),
        .odmem_rd_data(odmem_rd_data), .odmem_ack(odmem_ack), .odmem_err(odmem_err),
        .ostall(ostall),
        .omem_req(omem_req), .omem_we(omem_we), .omem_addr(omem_addr),
        .omem_wr_data(omem_wr_data), .omem_wr_be(omem_wr_be),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rd_data(imem_rd_data)
    );

    always #5 iclk = ~iclk;

    int n_checks = 0;
    int n_errors = 0;

    bit          chk_en = 0;
    bit          in_rst = 0;
    bit          exp_omem_req, exp_iack, exp_dack, exp_err, exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_idata, exp_ddata;
    logic [3:0]  exp_be;

    bit          i_pend, d_pend, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [1:0]  d_sz;
    bit          last_d;

    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we, cap_req, cap_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit model_bad(input logic [1:0] sz, input logic [1:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a != 2'd0);
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'd0:    return 4'b0001 << a;
            2'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_lane(input logic [1:0] sz, input logic [1:0] a, input logic [31:0] wd);
        case (sz)
            2'd0:    return {24'd0, wd[7:0]} << (8 * a);
            2'd1:    return {16'd0, wd[15:0]} << (16 * a[1]);
            default: return wd;
        endcase
    endfunction

    // Per-cycle comparison against the expectations the stimulus thread publishes.
    always @(negedge iclk) begin
        if (chk_en) begin
            chk("ostall", 32'(ostall), 32'((iimem_req & ~exp_iack) | (idmem_req & ~exp_dack)));
            chk("oimem_ack", 32'(oimem_ack), 32'(exp_iack));
            chk("odmem_ack", 32'(odmem_ack), 32'(exp_dack));
            chk("odmem_err", 32'(odmem_err), 32'(exp_err));
            chk("omem_req", 32'(omem_req), 32'(exp_omem_req));
            chk("oimem_rd_data", oimem_rd_data, exp_idata);
            if (exp_omem_req) begin
                chk("omem_addr", omem_addr, exp_addr);
                chk("omem_we", 32'(omem_we), 32'(exp_we));
                chk("omem_wr_be", 32'(omem_wr_be), 32'(exp_be));
                chk("omem_wr_data", omem_wr_data, exp_wdata);
            end
            if (exp_dack && !exp_err)
                chk("odmem_rd_data", odmem_rd_data, exp_ddata);
            if (in_rst) begin
                chk("rst_odmem_rd_data", odmem_rd_data, 32'd0);
                chk("rst_omem_addr", omem_addr, 32'd0);
                chk("rst_omem_wr_data", omem_wr_data, 32'd0);
                chk("rst_omem_wr_be", 32'(omem_wr_be), 32'd0);
                chk("rst_omem_we", 32'(omem_we), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge iclk);
        #1;
    endtask

    task automatic drive_req();
        iimem_req     = i_pend;
        iimem_addr    = i_addr;
        idmem_req     = d_pend;
        idmem_we      = d_we;
        idmem_addr    = d_addr;
        idmem_wr_data = d_wdata;
        idmem_wr_be   = d_sz;
    endtask

    // Called at cycle 0 (arbiter idle, requests visible); returns at the next idle sampling cycle.
    task automatic serve(input int g, input int r, input bit stray, input logic [31:0] rdata);
        bit win_d;
        win_d  = (i_pend && d_pend) ? !last_d : d_pend;
        last_d = win_d;
        if (win_d && model_bad(d_sz, d_addr[1:0])) begin
            step();
            exp_dack = 1; exp_err = 1;
            cap_req = omem_req; cap_err = odmem_err;
            step();
            exp_dack = 0; exp_err = 0;
            d_pend = 0; drive_req();
            return;
        end
        if (win_d) begin
            exp_addr  = {d_addr[31:2], 2'b00};
            exp_we    = d_we;
            exp_be    = d_we ? model_be(d_sz, d_addr[1:0]) : 4'b0000;
            exp_wdata = d_we ? model_lane(d_sz, d_addr[1:0], d_wdata) : 32'd0;
        end else begin
            exp_addr  = {i_addr[31:2], 2'b00};
            exp_we    = 0;
            exp_be    = 4'b0000;
            exp_wdata = 32'd0;
        end
        for (int k = 1; k <= 1 + g; k++) begin
            step();
            if (k == 1) begin
                cap_addr = omem_addr; cap_we = omem_we; cap_be = omem_wr_be; cap_wdata = omem_wr_data;
            end
            exp_omem_req = 1;
            imem_gnt     = (k == 1 + g);
            imem_rvalid  = stray && (k < 1 + g) && (k == 1 || $urandom_range(0, 1) == 1);
            imem_rd_data = $urandom;
        end
        for (int k = 0; k <= r; k++) begin
            step();
            exp_omem_req = 0;
            imem_gnt     = 0;
            imem_rvalid  = (k == r);
            imem_rd_data = (k == r) ? rdata : $urandom;
        end
        step();
        imem_rvalid = 0;
        if (win_d) begin exp_dack = 1; exp_ddata = rdata; end
        else begin exp_iack = 1; exp_idata = rdata; end
        step();
        exp_iack = 0; exp_dack = 0;
        if (win_d) d_pend = 0; else i_pend = 0;
        drive_req();
    endtask

    initial begin
        logic [31:0] ia, da;
        irst_n = 0; in_rst = 1;
        i_pend = 0; d_pend = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0; d_sz = 0;
        last_d = 1;
        imem_gnt = 0; imem_rvalid = 0; imem_rd_data = 0;
        exp_omem_req = 0; exp_iack = 0; exp_dack = 0; exp_err = 0; exp_we = 0;
        exp_addr = 0; exp_wdata = 0; exp_be = 0; exp_idata = 0; exp_ddata = 0;
        drive_req();
        @(posedge iclk); #1;
        chk_en = 1;
        step(); step();
        irst_n = 1; in_rst = 0;
        step();

        // First tie after reset goes to fetch.
        i_pend = 1; i_addr = 32'h300; d_pend = 1; d_we = 0; d_addr = 32'h404; d_sz = 2'd2; d_wdata = 0;
        drive_req();
        serve(0, 0, 0, $urandom);
        chk("pin_tie_first", cap_addr, 32'h300);
        serve(0, 1, 0, $urandom);
        chk("pin_tie_second", cap_addr, 32'h404);

        // Both always pending: grants alternate strictly.
        for (int p = 0; p < 6; p++) begin
            if (!i_pend) begin i_pend = 1; i_addr = 32'h1000 + 32'(p * 16); end
            if (!d_pend) begin d_pend = 1; d_we = 0; d_sz = 2'd2; d_addr = 32'h2000 + 32'(p * 16); end
            ia = i_addr; da = d_addr;
            drive_req();
            serve(0, 0, 0, $urandom);
            chk("pin_alternate", cap_addr, (p % 2 == 0) ? ia : da);
        end
        while (i_pend || d_pend) serve(0, 0, 0, $urandom);

        i_pend = 1; i_addr = 32'h100; drive_req();
        serve(0, 0, 0, 32'hDEADBEEF);
        chk("pin_fetch_data", oimem_rd_data, 32'hDEADBEEF);

        d_pend = 1; d_we = 1; d_addr = 32'h203; d_sz = 2'd0; d_wdata = 32'h000000A5; drive_req();
        serve(0, 0, 0, $urandom);
        chk("pin_byte_addr", cap_addr, 32'h200);
        chk("pin_byte_be", 32'(cap_be), 32'h8);
        chk("pin_byte_data", cap_wdata, 32'hA5000000);
        chk("pin_byte_we", 32'(cap_we), 32'd1);

        d_pend = 1; d_we = 1; d_addr = 32'h202; d_sz = 2'd1; d_wdata = 32'h00001234; drive_req();
        serve(0, 0, 0, $urandom);
        chk("pin_half_be", 32'(cap_be), 32'hC);
        chk("pin_half_data", cap_wdata, 32'h12340000);

        d_pend = 1; d_we = 1; d_addr = 32'h201; d_sz = 2'd2; d_wdata = 32'h11223344; drive_req();
        serve(0, 0, 0, $urandom);
        chk("pin_misaligned_req", 32'(cap_req), 32'd0);
        chk("pin_misaligned_err", 32'(cap_err), 32'd1);

        i_pend = 1; i_addr = 32'h180; drive_req();
        serve(5, 0, 1, 32'hCAFEF00D);
        chk("pin_slow_gnt_data", oimem_rd_data, 32'hCAFEF00D);

        // Reset while waiting for the response; the late response must be dropped.
        i_pend = 1; i_addr = 32'h500; drive_req();
        step();
        exp_omem_req = 1; exp_addr = 32'h500; exp_we = 0; exp_be = 0; exp_wdata = 0; imem_gnt = 1;
        step();
        exp_omem_req = 0; imem_gnt = 0;
        irst_n = 0; in_rst = 1;
        i_pend = 0; d_pend = 0; drive_req();
        exp_idata = 0; exp_ddata = 0; last_d = 1;
        step(); step();
        irst_n = 1; in_rst = 0;
        step();
        imem_rvalid = 1; imem_rd_data = 32'h0BADF00D;
        step();
        imem_rvalid = 0;
        step(); step();
        chk("pin_rst_dropped", oimem_rd_data, 32'd0);
        i_pend = 1; i_addr = 32'h600; drive_req();
        serve(1, 1, 0, 32'h600D600D);
        chk("pin_after_rst", oimem_rd_data, 32'h600D600D);

        for (int it = 0; it < 400; it++) begin
            if (!i_pend && $urandom_range(0, 9) < 6) begin
                i_pend = 1; i_addr = $urandom;
            end
            if (!d_pend && $urandom_range(0, 9) < 6) begin
                d_pend = 1; d_we = 1'($urandom_range(0, 1)); d_sz = 2'($urandom_range(0, 3));
                d_addr = $urandom; d_wdata = $urandom;
                if ($urandom_range(0, 1) == 1) d_addr[1:0] = 2'b00;
            end
            drive_req();
            if (i_pend || d_pend)
                serve($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom);
            else
                step();
        end

        step();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
